// File: rtl/spi_master_multi.sv
// Multi-target SPI master with run-time CPOL/CPHA, bit order and clock prescaler.
// Define SPI_MASTER_TXBUF_EN to add a 1-entry tx holding buffer for gapless words.
module spi_master_multi #(
  parameter int NUM_TARGETS = 1,
  parameter int DATA_W      = 8,
  parameter int PRESC_W     = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [PRESC_W-1:0]     prescaler_i,
  input  logic                   cpol_i,
  input  logic                   cpha_i,
  input  logic                   lsb_first_i,
  output logic                   spi_clk_o,
  output logic [NUM_TARGETS-1:0] spi_csn_o,
  output logic                   spi_mosi_o,
  output logic                   spi_mosi_drive_o,
  input  logic                   spi_miso_i,
  input  logic [NUM_TARGETS-1:0] target_id_i,
  input  logic                   target_en_i,
  input  logic [DATA_W-1:0]      tx_word_i,
  input  logic                   tx_en_i,
  output logic                   tx_ready_o,
  output logic [DATA_W-1:0]      rx_word_o,
  output logic                   rx_en_o,
  output logic                   rxtx_busy_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_LEAD  = 3'd3;
  localparam logic [2:0] S_TRAIL = 3'd4;

  localparam int CNT_W = $clog2(DATA_W);

  logic [2:0]             state;
  logic [PRESC_W-1:0]     div_cnt;
  logic                   div_done;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   cpol_q;
  logic                   cpha_q;
  logic                   lsb_q;
  logic [DATA_W-1:0]      tx_sh;
  logic [DATA_W-1:0]      tx_next;
  logic [DATA_W-1:0]      rx_sh;
  logic [DATA_W-1:0]      rx_sampled;
  logic                   clk_q;
  logic                   mosi_q;
  logic [NUM_TARGETS-1:0] csn_q;
  logic [DATA_W-1:0]      rx_word_q;
  logic                   rx_en_q;
  logic                   start_ready;
  logic                   chain_start;
  logic [DATA_W-1:0]      start_word;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  assign div_done   = (div_cnt == '0);
  assign tx_next    = lsb_q ? {1'b0, tx_sh[DATA_W-1:1]} : {tx_sh[DATA_W-2:0], 1'b0};
  assign rx_sampled = lsb_q ? {spi_miso_i, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], spi_miso_i};

`ifdef SPI_MASTER_TXBUF_EN
  logic              buf_valid;
  logic [DATA_W-1:0] buf_word;

  assign start_ready = (state == S_READY) && (buf_valid || tx_en_i);
  assign start_word  = buf_valid ? buf_word : tx_word_i;
  assign chain_start = buf_valid;
  assign tx_ready_o  = !buf_valid &&
                       ((state == S_READY) || (state == S_LEAD) || (state == S_TRAIL));
  assign rxtx_busy_o = (state == S_SETUP) || (state == S_LEAD) || (state == S_TRAIL) ||
                       ((state == S_READY) && buf_valid);
`else
  assign start_ready = (state == S_READY) && tx_en_i;
  assign start_word  = tx_word_i;
  assign chain_start = 1'b0;
  assign tx_ready_o  = (state == S_READY);
  assign rxtx_busy_o = (state == S_SETUP) || (state == S_LEAD) || (state == S_TRAIL);
`endif

  assign spi_clk_o        = clk_q;
  assign spi_csn_o        = csn_q;
  assign spi_mosi_o       = mosi_q;
  assign spi_mosi_drive_o = (state != S_IDLE);
  assign rx_word_o        = rx_word_q;
  assign rx_en_o          = rx_en_q;

  // Deselect has priority over everything, including a word in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      clk_q     <= 1'b0;
      mosi_q    <= 1'b0;
      csn_q     <= '1;
      rx_word_q <= '0;
      rx_en_q   <= 1'b0;
`ifdef SPI_MASTER_TXBUF_EN
      buf_valid <= 1'b0;
      buf_word  <= '0;
`endif
    end else if (!target_en_i) begin
      state   <= S_IDLE;
      csn_q   <= '1;
      clk_q   <= cpol_i;
      rx_en_q <= 1'b0;
`ifdef SPI_MASTER_TXBUF_EN
      buf_valid <= 1'b0;
`endif
    end else begin
      rx_en_q <= 1'b0;
      csn_q   <= ~target_id_i;
`ifdef SPI_MASTER_TXBUF_EN
      if (tx_en_i && !buf_valid && ((state == S_LEAD) || (state == S_TRAIL))) begin
        buf_valid <= 1'b1;
        buf_word  <= tx_word_i;
      end
`endif
      case (state)
        S_IDLE: begin
          state   <= S_SETUP;
          div_cnt <= prescaler_i;
          clk_q   <= cpol_i;
          cpol_q  <= cpol_i;
          cpha_q  <= cpha_i;
          lsb_q   <= lsb_first_i;
        end
        S_SETUP: begin
          if (div_done) state <= S_READY;
          else          div_cnt <= div_cnt - PRESC_W'(1);
        end
        S_READY: begin
          if (start_ready) begin
            tx_sh   <= start_word;
            bit_cnt <= CNT_W'(DATA_W - 1);
            if (!cpha_q) mosi_q <= first_bit(start_word, lsb_q);
            div_cnt <= prescaler_i;
            state   <= S_LEAD;
`ifdef SPI_MASTER_TXBUF_EN
            buf_valid <= 1'b0;
`endif
          end
        end
        S_LEAD: begin
          if (div_done) begin
            clk_q   <= ~cpol_q;
            div_cnt <= prescaler_i;
            state   <= S_TRAIL;
            if (!cpha_q) begin
              rx_sh <= rx_sampled;
            end else begin
              mosi_q <= first_bit(tx_sh, lsb_q);
              tx_sh  <= tx_next;
            end
          end else begin
            div_cnt <= div_cnt - PRESC_W'(1);
          end
        end
        S_TRAIL: begin
          if (div_done) begin
            clk_q   <= cpol_q;
            div_cnt <= prescaler_i;
            if (cpha_q) begin
              rx_sh <= rx_sampled;
            end else begin
              tx_sh  <= tx_next;
              mosi_q <= first_bit(tx_next, lsb_q);
            end
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - CNT_W'(1);
              state   <= S_LEAD;
            end else begin
              rx_word_q <= cpha_q ? rx_sampled : rx_sh;
              rx_en_q   <= 1'b1;
              // A buffered word skips READY; its load overrides the shift above.
              if (chain_start) begin
                tx_sh   <= start_word;
                bit_cnt <= CNT_W'(DATA_W - 1);
                if (!cpha_q) mosi_q <= first_bit(start_word, lsb_q);
                state   <= S_LEAD;
`ifdef SPI_MASTER_TXBUF_EN
                buf_valid <= 1'b0;
`endif
              end else begin
                state <= S_READY;
              end
            end
          end else begin
            div_cnt <= div_cnt - PRESC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Randomised self-checking bench for spi_master_multi (3 targets, 8-bit words).
// Expected words, MOSI bit order and latency come from a bit-sequence model of the SPI rules.
module tb_spi_master_multi;

  localparam int NT = 3;
  localparam int DW = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [PW-1:0] prescaler;
  logic          cpol, cpha, lsb_first;
  logic          spi_clk, spi_mosi, spi_mosi_drive, spi_miso;
  logic [NT-1:0] spi_csn, target_id;
  logic          target_en;
  logic [DW-1:0] tx_word, rx_word;
  logic          tx_en, tx_ready, rx_en, busy;

  int vectors = 0;
  int miscompares = 0;

  bit          mon_en = 1'b0;
  bit          loopback = 1'b0;
  logic [DW-1:0] pat = '0;
  logic        cur_cpol = 1'b0, cur_cpha = 1'b0, cur_lsb = 1'b0;
  int          bidx = 0;
  int          edges = 0;
  logic        mosi_bits[$];
  logic        prev_sclk = 1'b0;
  logic        pat_bit;
  logic [2:0]  pidx;
  logic [DW-1:0] last_rx = '0;

  spi_master_multi #(.NUM_TARGETS(NT), .DATA_W(DW), .PRESC_W(PW)) dut (
    .clk(clk), .resetn(resetn), .prescaler_i(prescaler),
    .cpol_i(cpol), .cpha_i(cpha), .lsb_first_i(lsb_first),
    .spi_clk_o(spi_clk), .spi_csn_o(spi_csn), .spi_mosi_o(spi_mosi),
    .spi_mosi_drive_o(spi_mosi_drive), .spi_miso_i(spi_miso),
    .target_id_i(target_id), .target_en_i(target_en),
    .tx_word_i(tx_word), .tx_en_i(tx_en), .tx_ready_o(tx_ready),
    .rx_word_o(rx_word), .rx_en_o(rx_en), .rxtx_busy_o(busy)
  );

  always #5 clk = ~clk;

  // The slave model serves pattern bits in wire order and records MOSI at each sampling edge.
  always_comb begin
    pidx    = cur_lsb ? 3'(bidx) : 3'(DW - 1 - bidx);
    pat_bit = (bidx < DW) ? pat[pidx] : 1'b0;
  end
  assign spi_miso = loopback ? spi_mosi : pat_bit;

  always @(negedge clk) begin
    if (!mon_en) begin
      bidx = 0;
      edges = 0;
      mosi_bits.delete();
    end else if (spi_clk !== prev_sclk) begin
      edges = edges + 1;
      if ((spi_clk !== cur_cpol) != cur_cpha) begin
        mosi_bits.push_back(spi_mosi);
        bidx = bidx + 1;
      end
    end
    prev_sclk = spi_clk;
  end

  function automatic logic [DW-1:0] mosi_word();
    logic [DW-1:0] r;
    r = '0;
    if (mosi_bits.size() < DW) return 'x;
    for (int k = 0; k < DW; k++) r[cur_lsb ? k : DW - 1 - k] = mosi_bits[k];
    return r;
  endfunction

  task automatic select_target(input logic pol, input logic ph, input logic lsbf,
                               input logic [PW-1:0] p, input logic [NT-1:0] id, output int cyc);
    target_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cpol = pol; cpha = ph; lsb_first = lsbf;
    cur_cpol = pol; cur_cpha = ph; cur_lsb = lsbf;
    prescaler = p; target_id = id; target_en = 1'b1;
    cyc = -1;
    for (int i = 1; i < 300; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin cyc = i; break; end
    end
  endtask

  task automatic xfer(input logic [DW-1:0] w, output int lat);
    time t0;
    lat = -1;
    tx_word = w; tx_en = 1'b1; mon_en = 1'b1;
    @(posedge clk);
    t0 = $time;
    @(negedge clk);
    tx_en = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rx_en === 1'b1) begin lat = int'(($time - t0 - 5) / 10); break; end
      @(negedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; target_en = 1'b0; tx_en = 1'b0; tx_word = '0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; prescaler = '0; target_id = 3'b001;
    #23;
    vectors++; if (spi_csn !== 3'b111) begin miscompares++; $display("[TB] FAIL reset_csn: got %b want 111", spi_csn); end
    vectors++; if (spi_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sclk: got %b want 0", spi_clk); end
    vectors++; if (spi_mosi !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mosi: got %b want 0", spi_mosi); end
    vectors++; if (spi_mosi_drive !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_drive: got %b want 0", spi_mosi_drive); end
    vectors++; if (rx_word !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rxword: got %h want 00", rx_word); end
    vectors++; if (rx_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rxen: got %b want 0", rx_en); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_txready: got %b want 0", tx_ready); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mode0();
    int cyc, lat;
    select_target(1'b0, 1'b0, 1'b0, 8'd0, 3'b001, cyc);
    vectors++; if (cyc !== 2) begin miscompares++; $display("[TB] FAIL m0_setup_len: got %0d want 2", cyc); end
    vectors++; if (spi_csn !== 3'b110) begin miscompares++; $display("[TB] FAIL m0_csn: got %b want 110", spi_csn); end
    vectors++; if (spi_mosi_drive !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL m0_ready_flags: got drive=%b busy=%b want 1/0", spi_mosi_drive, busy); end
    loopback = 1'b1;
    xfer(8'hA5, lat);
    vectors++; if (lat !== 16) begin miscompares++; $display("[TB] FAIL m0_latency: got %0d want 16", lat); end
    vectors++; if (rx_word !== 8'hA5) begin miscompares++; $display("[TB] FAIL m0_rx: got %h want a5", rx_word); end
    vectors++; if (edges !== 16) begin miscompares++; $display("[TB] FAIL m0_edges: got %0d want 16", edges); end
    vectors++; if (mosi_word() !== 8'hA5) begin miscompares++; $display("[TB] FAIL m0_mosi: got %h want a5", mosi_word()); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL m0_ready_with_rxen: got %b want 1", tx_ready); end
    @(negedge clk); #1;
    vectors++; if (rx_en !== 1'b0) begin miscompares++; $display("[TB] FAIL m0_rxen_pulse: got %b want 0", rx_en); end
    mon_en = 1'b0; last_rx = 8'hA5;
  endtask

  task automatic test_mode3();
    int cyc, lat;
    select_target(1'b1, 1'b1, 1'b0, 8'd2, 3'b010, cyc);
    vectors++; if (spi_clk !== 1'b1) begin miscompares++; $display("[TB] FAIL m3_idle_high: got %b want 1", spi_clk); end
    vectors++; if (cyc !== 4) begin miscompares++; $display("[TB] FAIL m3_setup_len: got %0d want 4", cyc); end
    loopback = 1'b0; pat = 8'h96;
    xfer(8'h3C, lat);
    vectors++; if (lat !== 48) begin miscompares++; $display("[TB] FAIL m3_latency: got %0d want 48", lat); end
    vectors++; if (rx_word !== 8'h96) begin miscompares++; $display("[TB] FAIL m3_rx: got %h want 96", rx_word); end
    vectors++; if (mosi_word() !== 8'h3C) begin miscompares++; $display("[TB] FAIL m3_mosi: got %h want 3c", mosi_word()); end
    vectors++; if (edges !== 16) begin miscompares++; $display("[TB] FAIL m3_edges: got %0d want 16", edges); end
    mon_en = 1'b0; last_rx = 8'h96;
  endtask

  task automatic test_lsb_first();
    int cyc, lat;
    logic [3:0] head;
    select_target(1'b0, 1'b0, 1'b1, 8'd1, 3'b001, cyc);
    loopback = 1'b1;
    xfer(8'h34, lat);
    head = (mosi_bits.size() >= 4) ? {mosi_bits[0], mosi_bits[1], mosi_bits[2], mosi_bits[3]} : 4'bxxxx;
    vectors++; if (head !== 4'b0010) begin miscompares++; $display("[TB] FAIL lsb_head: got %b want 0010", head); end
    vectors++; if (rx_word !== 8'h34) begin miscompares++; $display("[TB] FAIL lsb_rx: got %h want 34", rx_word); end
    vectors++; if (lat !== 32) begin miscompares++; $display("[TB] FAIL lsb_latency: got %0d want 32", lat); end
    mon_en = 1'b0; last_rx = 8'h34;
  endtask

  task automatic test_random();
    int cyc, lat, p;
    logic pol, ph, lsbf;
    logic [NT-1:0] id;
    logic [DW-1:0] w, exp_rx;
    for (int n = 0; n < 6; n++) begin
      pol = 1'($urandom_range(0, 1)); ph = 1'($urandom_range(0, 1)); lsbf = 1'($urandom_range(0, 1));
      p = $urandom_range(0, 3);
      id = NT'(1) << $urandom_range(0, NT - 1);
      w = DW'($urandom); pat = DW'($urandom); loopback = 1'($urandom_range(0, 1));
      exp_rx = loopback ? w : pat;
      select_target(pol, ph, lsbf, PW'(p), id, cyc);
      vectors++; if (spi_csn !== ~id) begin miscompares++; $display("[TB] FAIL rnd%0d_csn: got %b want %b", n, spi_csn, ~id); end
      xfer(w, lat);
      vectors++; if (rx_word !== exp_rx) begin miscompares++; $display("[TB] FAIL rnd%0d_rx: got %h want %h (mode %b%b lsb %b)", n, rx_word, exp_rx, pol, ph, lsbf); end
      vectors++; if (lat !== 2 * DW * (p + 1)) begin miscompares++; $display("[TB] FAIL rnd%0d_latency: got %0d want %0d", n, lat, 2 * DW * (p + 1)); end
      vectors++; if (mosi_word() !== w) begin miscompares++; $display("[TB] FAIL rnd%0d_mosi: got %h want %h", n, mosi_word(), w); end
      mon_en = 1'b0; last_rx = exp_rx;
    end
  endtask

  task automatic test_back_to_back();
    int cyc, pulses, csn_bad, gap;
    logic [DW-1:0] got [2];
    got[0] = 'x; got[1] = 'x;
    pulses = 0; csn_bad = 0; gap = 0;
    select_target(1'b0, 1'b0, 1'b0, 8'd0, 3'b100, cyc);
    loopback = 1'b1;
    tx_word = 8'h11; tx_en = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 400 && pulses < 2; i++) begin
      @(negedge clk); #1;
      if (spi_csn !== 3'b011) csn_bad++;
      if (rx_en === 1'b1) begin
        got[pulses] = rx_word;
        pulses++;
        if (pulses == 1) begin tx_word = 8'h22; gap = (tx_ready === 1'b1) ? 1 : 0; end
      end else if (pulses == 1) begin
        if (tx_ready === 1'b1) gap++;
        tx_en = 1'b0;
      end
    end
    tx_en = 1'b0; mon_en = 1'b0;
    vectors++; if (pulses !== 2) begin miscompares++; $display("[TB] FAIL b2b_pulses: got %0d want 2", pulses); end
    vectors++; if (got[0] !== 8'h11) begin miscompares++; $display("[TB] FAIL b2b_word0: got %h want 11", got[0]); end
    vectors++; if (got[1] !== 8'h22) begin miscompares++; $display("[TB] FAIL b2b_word1: got %h want 22", got[1]); end
    vectors++; if (csn_bad !== 0) begin miscompares++; $display("[TB] FAIL b2b_csn: got %0d bad cycles want 0", csn_bad); end
`ifndef SPI_MASTER_TXBUF_EN
    vectors++; if (gap !== 1) begin miscompares++; $display("[TB] FAIL b2b_gap: got %0d ready cycles want 1", gap); end
`endif
    last_rx = 8'h22;
  endtask

  task automatic test_deselect();
    int cyc, leads, saw;
    logic prev;
    leads = 0; saw = 0;
    select_target(1'b0, 1'b0, 1'b0, 8'd1, 3'b001, cyc);
    loopback = 1'b1;
    tx_word = DW'($urandom); tx_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_en = 1'b0;
    prev = spi_clk;
    for (int i = 0; i < 200 && leads < 3; i++) begin
      @(negedge clk);
      if (spi_clk !== prev && spi_clk !== cur_cpol) leads++;
      prev = spi_clk;
    end
    target_en = 1'b0;
    @(negedge clk); #1;
    vectors++; if (leads !== 3) begin miscompares++; $display("[TB] FAIL desel_leads: got %0d want 3", leads); end
    vectors++; if (spi_csn !== 3'b111) begin miscompares++; $display("[TB] FAIL desel_csn: got %b want 111", spi_csn); end
    vectors++; if (spi_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL desel_sclk: got %b want 0", spi_clk); end
    vectors++; if (spi_mosi_drive !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL desel_flags: got drive=%b busy=%b want 0/0", spi_mosi_drive, busy); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_en !== 1'b0) saw++;
    end
    vectors++; if (saw !== 0) begin miscompares++; $display("[TB] FAIL desel_rxen: got %0d pulses want 0", saw); end
    vectors++; if (rx_word !== last_rx) begin miscompares++; $display("[TB] FAIL desel_rxword: got %h want %h", rx_word, last_rx); end
  endtask

  task automatic test_async_reset();
    int cyc;
    select_target(1'b1, 1'b0, 1'b0, 8'd1, 3'b010, cyc);
    tx_word = 8'hFF; tx_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_en = 1'b0;
    repeat (7) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    vectors++; if (spi_csn !== 3'b111) begin miscompares++; $display("[TB] FAIL arst_csn: got %b want 111", spi_csn); end
    vectors++; if (spi_clk !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_sclk: got %b want 0", spi_clk); end
    vectors++; if (spi_mosi !== 1'b0 || spi_mosi_drive !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_mosi: got %b/%b want 0/0", spi_mosi, spi_mosi_drive); end
    vectors++; if (rx_word !== 8'h00 || rx_en !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_rx: got %h/%b want 00/0", rx_word, rx_en); end
    vectors++; if (busy !== 1'b0 || tx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_status: got busy=%b ready=%b want 0/0", busy, tx_ready); end
    target_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_lsb_first();
    test_random();
    test_back_to_back();
    test_deselect();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
